// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types, default constants and popcount helper for the LIF step scheduler
package lif_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HIDDEN = 3'd1,
        SUM    = 3'd2,
        OUTPUT = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int DEF_N_NEURONS  = 8;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_THRESH     = 200;
    localparam int DEF_LEAK_SHIFT = 1;
    localparam int MAX_NEURONS    = 16;

    // Sixteen inputs at most, so five bits always hold the count.
    function automatic logic [4:0] popcount(input logic [MAX_NEURONS-1:0] bits);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_NEURONS; i++) begin
            cnt = cnt + {4'd0, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lif_step_scheduler_if.sv
// rtl/lif_step_scheduler_if.sv - control, input-current and spike-output bundle of the LIF step scheduler
interface lif_step_scheduler_if
    import lif_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int WIDTH     = DEF_WIDTH
);

    logic                       start;
    logic                       clr_state;
    logic [N_NEURONS*WIDTH-1:0] current;
    logic                       busy;
    logic                       done;
    logic [N_NEURONS-1:0]       spike_vec;
    logic                       out_spike;
    logic [WIDTH-1:0]           out_state;

    modport master (
        output start,
        output clr_state,
        output current,
        input  busy,
        input  done,
        input  spike_vec,
        input  out_spike,
        input  out_state
    );

    modport slave (
        input  start,
        input  clr_state,
        input  current,
        output busy,
        output done,
        output spike_vec,
        output out_spike,
        output out_state
    );

endinterface

// File: rtl/lif_update_core.sv
// rtl/lif_update_core.sv - combinational leak, integrate, saturate and fire for one neuron
module lif_update_core #(
    parameter int WIDTH      = 8,
    parameter int THRESH     = 200,
    parameter int LEAK_SHIFT = 1
) (
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH-1:0] i_in_i,
    output logic [WIDTH-1:0] v_store_o,
    output logic             spike_o
);

    localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);

    logic [WIDTH-1:0] leaked;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] v_next;

    assign leaked = v_i - (v_i >> LEAK_SHIFT);
    assign sum    = {1'b0, leaked} + {1'b0, i_in_i};

    // Carry out of the WIDTH-bit add means overflow: clamp to full scale.
    assign v_next    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    assign spike_o   = (v_next >= THRESH_W);
    assign v_store_o = spike_o ? '0 : v_next;

endmodule

// File: rtl/lif_step_scheduler.sv
// rtl/lif_step_scheduler.sv - sequences N hidden neurons and one output neuron through a shared LIF datapath
module lif_step_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int THRESH     = DEF_THRESH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic               clk,
    input  logic               rst_n,
    lif_step_scheduler_if.slave bus
);

    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;

    logic [N_NEURONS*WIDTH-1:0] snap_q;
    logic [WIDTH-1:0]           v_q [N_NEURONS];
    logic [WIDTH-1:0]           vout_q;
    logic [N_NEURONS-1:0]       shadow_q;
    logic [WIDTH-1:0]           pop_q;

    logic [N_NEURONS-1:0]       spike_vec_q;
    logic                       out_spike_q;
    logic [WIDTH-1:0]           out_state_q;

    logic [WIDTH-1:0]           core_v;
    logic [WIDTH-1:0]           core_i;
    logic [WIDTH-1:0]           core_v_store;
    logic                       core_spike;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = HIDDEN;
                    idx_d   = '0;
                end
            end
            HIDDEN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = SUM;
                    idx_d   = '0;
                end
            end
            SUM:     state_d = OUTPUT;
            OUTPUT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The single datapath sees a hidden neuron during HIDDEN and the output neuron otherwise.
    always_comb begin
        core_v = vout_q;
        core_i = pop_q;
        if (state_q == HIDDEN) begin
            core_v = v_q[idx_q];
            core_i = snap_q[idx_q*WIDTH +: WIDTH];
        end
    end

    lif_update_core #(
        .WIDTH      (WIDTH),
        .THRESH     (THRESH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_core (
        .v_i       (core_v),
        .i_in_i    (core_i),
        .v_store_o (core_v_store),
        .spike_o   (core_spike)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q      <= '0;
            vout_q      <= '0;
            shadow_q    <= '0;
            pop_q       <= '0;
            spike_vec_q <= '0;
            out_spike_q <= 1'b0;
            out_state_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        snap_q <= bus.current;
                    end else if (bus.clr_state) begin
                        vout_q <= '0;
                        for (int i = 0; i < N_NEURONS; i++) begin
                            v_q[i] <= '0;
                        end
                    end
                end
                HIDDEN: begin
                    v_q[idx_q]      <= core_v_store;
                    shadow_q[idx_q] <= core_spike;
                end
                SUM: begin
                    pop_q <= WIDTH'(popcount(MAX_NEURONS'(shadow_q)));
                end
                OUTPUT: begin
                    // All visible results change on the same edge so no partial step leaks out.
                    vout_q      <= core_v_store;
                    spike_vec_q <= shadow_q;
                    out_spike_q <= core_spike;
                    out_state_q <= core_v_store;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.spike_vec = spike_vec_q;
    assign bus.out_spike = out_spike_q;
    assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// tb/tb_lif_step_scheduler.sv - directed scoreboard bench for lif_step_scheduler
module tb_lif_step_scheduler;
    import lif_pkg::*;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int TH = 200;
    localparam int LS = 1;

    typedef struct {
        logic [N-1:0] sv;
        logic         os;
        logic [W-1:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lif_step_scheduler_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_step_scheduler #(
        .N_NEURONS  (N),
        .WIDTH      (W),
        .THRESH     (TH),
        .LEAK_SHIFT (LS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mv[N+1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void neuron(input int v, input int i, output int vs, output bit sp);
        int nx;
        nx = v - (v >> LS) + i;
        if (nx > (1 << W) - 1) nx = (1 << W) - 1;
        sp = (nx >= TH);
        vs = sp ? 0 : nx;
    endfunction

    task automatic model_step(input logic [N*W-1:0] cur);
        exp_t e;
        int   pop;
        int   vs;
        bit   sp;
        pop = 0;
        for (int k = 0; k < N; k++) begin
            neuron(mv[k], int'(cur[k*W +: W]), vs, sp);
            mv[k]   = vs;
            e.sv[k] = sp;
            pop     = pop + int'(sp);
        end
        neuron(mv[N], pop, vs, sp);
        mv[N] = vs;
        e.os  = sp;
        e.st  = W'(vs);
        sb.push_back(e);
    endtask

    task automatic model_clear;
        for (int k = 0; k <= N; k++) mv[k] = 0;
    endtask

    function automatic logic [N*W-1:0] all_cur(input logic [W-1:0] val);
        logic [N*W-1:0] c;
        for (int k = 0; k < N; k++) c[k*W +: W] = val;
        return c;
    endfunction

    task automatic clear_state;
        bus.clr_state = 1'b1;
        tick;
        bus.clr_state = 1'b0;
        model_clear();
    endtask

    // Runs one step; optionally pulses start mid-step and scrambles the current bus.
    task automatic run_step(input logic [N*W-1:0] cur, input string tag, input bit disturb);
        int   lat;
        exp_t e;
        bus.current = cur;
        bus.start   = 1'b1;
        model_step(cur);
        tick;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (disturb && (lat == 2 || lat == 5)) begin
                bus.start   = 1'b1;
                bus.current = ~cur;
            end
            tick;
            bus.start = 1'b0;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(N + 3));
        check({tag, " busy@done"}, 32'(bus.busy), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " spike_vec"}, 32'(bus.spike_vec), 32'(e.sv));
            check({tag, " out_spike"}, 32'(bus.out_spike), 32'(e.os));
            check({tag, " out_state"}, 32'(bus.out_state), 32'(e.st));
        end else begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end
        tick;
        check({tag, " done pulse"}, 32'(bus.done), 32'd0);
        check({tag, " busy after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int             seen;
        logic [N*W-1:0] cur;

        bus.start     = 1'b0;
        bus.clr_state = 1'b0;
        bus.current   = '0;
        model_clear();

        // 1: reset and idle
        repeat (3) tick;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.busy || bus.done) seen++;
            tick;
        end
        check("idle busy/done", 32'(seen), 32'd0);
        check("idle spike_vec", 32'(bus.spike_vec), 32'd0);
        check("idle out_state", 32'(bus.out_state), 32'd0);
        check("idle out_spike", 32'(bus.out_spike), 32'd0);

        // 2: all zero currents
        run_step('0, "zero", 1'b0);
        check("zero spec sv", 32'(bus.spike_vec), 32'h00);

        // 3: single neuron at threshold
        clear_state();
        cur = '0;
        cur[0 +: W] = W'(200);
        run_step(cur, "n0", 1'b0);
        check("n0 spec sv", 32'(bus.spike_vec), 32'h01);
        check("n0 spec state", 32'(bus.out_state), 32'd1);

        // 4: all 150 over two steps
        clear_state();
        run_step(all_cur(W'(150)), "c150a", 1'b0);
        check("c150a spec sv", 32'(bus.spike_vec), 32'h00);
        run_step(all_cur(W'(150)), "c150b", 1'b0);
        check("c150b spec sv", 32'(bus.spike_vec), 32'hFF);
        check("c150b spec state", 32'(bus.out_state), 32'd8);

        // clr_state leaves outputs alone but zeroes potentials
        clear_state();
        tick;
        check("clr holds sv", 32'(bus.spike_vec), 32'hFF);
        check("clr holds state", 32'(bus.out_state), 32'd8);
        run_step(all_cur(W'(150)), "postclr", 1'b0);
        check("postclr spec sv", 32'(bus.spike_vec), 32'h00);

        // 5: saturation on neuron 3
        clear_state();
        cur = '0;
        cur[3*W +: W] = W'(199);
        run_step(cur, "sat1", 1'b0);
        check("sat1 spec sv", 32'(bus.spike_vec), 32'h00);
        run_step(cur, "sat2", 1'b0);
        check("sat2 spec sv", 32'(bus.spike_vec), 32'h08);

        // 6a: start while busy is ignored, snapshot unaffected
        clear_state();
        run_step(all_cur(W'(150)), "busystart", 1'b1);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.done || bus.busy) seen++;
            tick;
        end
        check("busystart no extra step", 32'(seen), 32'd0);

        // 6b: reset at HIDDEN k=3
        bus.current = all_cur(W'(150));
        bus.start   = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        model_clear();
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst spike_vec", 32'(bus.spike_vec), 32'd0);
        check("rst out_state", 32'(bus.out_state), 32'd0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.done) seen++;
            tick;
        end
        check("rst no done", 32'(seen), 32'd0);
        run_step(all_cur(W'(150)), "fresh", 1'b0);
        check("fresh spec sv", 32'(bus.spike_vec), 32'h00);
        check("fresh spec state", 32'(bus.out_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
